// File: rtl/riscv_pkg.sv
// Shared types and helpers for the mul/div scheduler and other recall-aware queues.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } MdState;

  localparam int unsigned MUL_LAT_DEFAULT = 3;
  localparam int unsigned DIV_LAT_DEFAULT = 34;

  // True when addr lies in [new_front, old_front) on a ring of 2^w entries.
  function automatic logic al_in_range(input logic [31:0] addr, input logic [31:0] new_front,
                                       input logic [31:0] old_front, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((addr - new_front) & mask) < ((old_front - new_front) & mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the lane at i_ptr has priority, then the following lanes in ring order.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_j = (32'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Schedules the shared iterative mul/div unit among issue lanes, times its fixed latency and
// holds the result tag for writeback; squashes the in-flight op on flush or covering recall.
module muldiv_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned AL_W    = 5,
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT,
  localparam int unsigned SEL_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_is_div,
  input  logic [5:0]         req_rd      [NUM_REQ],
  input  logic [AL_W-1:0]    req_al_addr [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  input  logic               ext_stall,
  input  logic               ext_flush,
  input  logic               if_recall,
  input  logic [AL_W-1:0]    new_front,
  input  logic [AL_W-1:0]    old_front,
  output logic               unit_start,
  output logic [SEL_W-1:0]   unit_sel,
  output logic               unit_is_div,
  output logic               unit_kill,
  output logic               unit_busy,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [5:0]         wb_rd,
  output logic [AL_W-1:0]    wb_al_addr,
  output logic [SEL_W-1:0]   wb_lane
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT);

  MdState           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] r_lane;
  logic [5:0]       r_rd;
  logic [AL_W-1:0]  r_al;

  logic [NUM_REQ-1:0] w_grant;
  logic [SEL_W-1:0]   w_idx;
  logic               w_any;
  logic               w_can_grant;
  logic               w_accept;
  logic               w_squash;
  logic               w_kill;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .i_req  (req_valid),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_can_grant = (r_state == IDLE) & ~ext_stall & ~ext_flush & ~if_recall;
  assign w_accept    = w_can_grant & w_any;
  assign req_ready   = w_can_grant ? w_grant : '0;

  assign w_squash = if_recall & al_in_range(32'(r_al), 32'(new_front), 32'(old_front), AL_W);
  assign w_kill   = (r_state != IDLE) & (ext_flush | w_squash);

  assign unit_start  = w_accept;
  assign unit_sel    = w_accept ? w_idx : '0;
  assign unit_is_div = w_accept & req_is_div[w_idx];
  assign unit_kill   = w_kill;
  assign unit_busy   = (r_state != IDLE);
  assign wb_valid    = (r_state == DONE) & ~w_kill;
  assign wb_rd       = r_rd;
  assign wb_al_addr  = r_al;
  assign wb_lane     = r_lane;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
      r_lane   <= '0;
      r_rd     <= '0;
      r_al     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= BUSY;
            r_rd     <= req_rd[w_idx];
            r_al     <= req_al_addr[w_idx];
            r_lane   <= w_idx;
            // Two cycles of latency are spent in the accept cycle and the BUSY->DONE step.
            r_cnt    <= req_is_div[w_idx] ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
            r_rr_ptr <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + SEL_W'(1);
          end
        end
        BUSY: begin
          if (w_kill)           r_state <= IDLE;
          else if (r_cnt == '0) r_state <= DONE;
          else                  r_cnt   <= r_cnt - CNT_W'(1);
        end
        DONE: begin
          if (w_kill || wb_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
